// File: rtl/riscv_bp_pkg.sv
// Shared branch-predictor types: 2-bit counter encodings, BTB entry layout,
// PC index/tag slicing helpers and the saturating counter step.
package riscv_bp_pkg;

   localparam int BP_PC_W  = 32;
   localparam int BP_IDX_W = 6;
   localparam int BP_TAG_W = BP_PC_W - BP_IDX_W - 2;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;
   localparam logic [1:0] CTR_RESET = WNT;

   typedef struct packed {
      logic                valid;
      logic [BP_TAG_W-1:0] tag;
      logic [BP_PC_W-1:0]  target;
   } btb_entry_t;

   // Word-aligned PCs: bits [1:0] never participate in index or tag.
   function automatic logic [BP_IDX_W-1:0] bp_idx(input logic [BP_PC_W-1:0] pc);
      return pc[BP_IDX_W+1:2];
   endfunction

   function automatic logic [BP_TAG_W-1:0] bp_tag(input logic [BP_PC_W-1:0] pc);
      return pc[BP_PC_W-1:BP_IDX_W+2];
   endfunction

   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      case (ctr)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? WT  : SNT;
         WT:      nxt = taken ? ST  : WNT;
         default: nxt = taken ? ST  : WT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Flop-based table with one combinational read port and one synchronous write
// port. SAT=1 steps a 2-bit saturating counter; SAT=0 stores wr_data verbatim.
module bp_counter_table
   import riscv_bp_pkg::*;
#(
   parameter int                DEPTH     = 64,
   parameter int                IDX_W     = 6,
   parameter int                DATA_W    = 2,
   parameter bit                SAT       = 1'b1,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic              wr_taken,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [DATA_W-1:0]            wr_val;
   logic                         unused;

   // Only one of wr_taken / wr_data matters for a given mode.
   assign unused = ^{wr_taken, wr_data};

   generate
      if (SAT) begin : g_sat
         assign wr_val = DATA_W'(ctr_next(mem[wr_idx][1:0], wr_taken));
      end else begin : g_raw
         assign wr_val = wr_data;
      end
   endgenerate

   // Read sees the array before this edge's write: collisions return old data.
   assign rd_data = mem[rd_idx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         mem <= {DEPTH{RESET_VAL}};
      else if (wr_en)
         mem[wr_idx] <= wr_val;
   end

endmodule

// File: rtl/branch_predictor.sv
// PC-indexed 2-bit counter predictor with FETCH->ISS->EX prediction pipeline.
// Optional direct-mapped BTB enabled by defining BRANCH_PRED_BTB_EN.
module branch_predictor
   import riscv_bp_pkg::*;
#(
   parameter int PC_W    = BP_PC_W,
   parameter int IDX_W   = BP_IDX_W,
   parameter int ENTRIES = 2**IDX_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W-1:0] pc_fetch_bp_i,
   input  logic            stall_iss_bp_i,
   input  logic            flush_iss_bp_i,
   input  logic            flush_ex_bp_i,
   input  logic            brn_ex_mem_bp_i,
   input  logic            branch_taken_ex_mem_bp_i,
   input  logic [PC_W-1:0] pc_ex_mem_bp_i,
   input  logic [PC_W-1:0] brn_tgt_ex_mem_bp_i,
   output logic            brn_pred_fetch_bp_o,
   output logic [PC_W-1:0] brn_tgt_fetch_bp_o,
   output logic            brn_pred_ex_mem_bp_o
);

   logic [1:0] ctr_rd;
   logic       iss_pred;
   logic       ex_pred;

   bp_counter_table #(
      .DEPTH    (ENTRIES),
      .IDX_W    (IDX_W),
      .DATA_W   (2),
      .SAT      (1'b1),
      .RESET_VAL(CTR_RESET)
   ) u_ctr_tbl (
      .clk     (clk),
      .reset   (reset),
      .rd_idx  (bp_idx(pc_fetch_bp_i)),
      .rd_data (ctr_rd),
      .wr_en   (brn_ex_mem_bp_i),
      .wr_idx  (bp_idx(pc_ex_mem_bp_i)),
      .wr_taken(branch_taken_ex_mem_bp_i),
      .wr_data (2'b00)
   );

`ifdef BRANCH_PRED_BTB_EN
   btb_entry_t btb_rd;
   btb_entry_t btb_wr;
   logic       btb_hit;

   assign btb_wr = '{valid: 1'b1, tag: bp_tag(pc_ex_mem_bp_i), target: brn_tgt_ex_mem_bp_i};

   // Only taken branches allocate; a not-taken outcome never needs a target.
   bp_counter_table #(
      .DEPTH    (ENTRIES),
      .IDX_W    (IDX_W),
      .DATA_W   ($bits(btb_entry_t)),
      .SAT      (1'b0),
      .RESET_VAL('0)
   ) u_btb_tbl (
      .clk     (clk),
      .reset   (reset),
      .rd_idx  (bp_idx(pc_fetch_bp_i)),
      .rd_data (btb_rd),
      .wr_en   (brn_ex_mem_bp_i & branch_taken_ex_mem_bp_i),
      .wr_idx  (bp_idx(pc_ex_mem_bp_i)),
      .wr_taken(1'b0),
      .wr_data (btb_wr)
   );

   assign btb_hit             = btb_rd.valid && (btb_rd.tag == bp_tag(pc_fetch_bp_i));
   assign brn_pred_fetch_bp_o = ctr_rd[1] & btb_hit;
   assign brn_tgt_fetch_bp_o  = btb_hit ? btb_rd.target : '0;
`else
   logic unused;

   assign unused              = ^brn_tgt_ex_mem_bp_i;
   assign brn_pred_fetch_bp_o = ctr_rd[1];
   assign brn_tgt_fetch_bp_o  = '0;
`endif

   // Flush outranks stall; the EX register has no stall of its own.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iss_pred <= 1'b0;
         ex_pred  <= 1'b0;
      end else begin
         if (flush_iss_bp_i)
            iss_pred <= 1'b0;
         else if (!stall_iss_bp_i)
            iss_pred <= brn_pred_fetch_bp_o;
         ex_pred <= flush_ex_bp_i ? 1'b0 : iss_pred;
      end
   end

   assign brn_pred_ex_mem_bp_o = ex_pred;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; BTB checks run when BRANCH_PRED_BTB_EN is defined.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_fetch;
   logic        stall_iss, flush_iss, flush_ex;
   logic        brn_ex, taken;
   logic [31:0] pc_ex, tgt_ex;
   logic        pred_fetch;
   logic [31:0] tgt_fetch;
   logic        pred_ex;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk                     (clk),
      .reset                   (reset),
      .pc_fetch_bp_i           (pc_fetch),
      .stall_iss_bp_i          (stall_iss),
      .flush_iss_bp_i          (flush_iss),
      .flush_ex_bp_i           (flush_ex),
      .brn_ex_mem_bp_i         (brn_ex),
      .branch_taken_ex_mem_bp_i(taken),
      .pc_ex_mem_bp_i          (pc_ex),
      .brn_tgt_ex_mem_bp_i     (tgt_ex),
      .brn_pred_fetch_bp_o     (pred_fetch),
      .brn_tgt_fetch_bp_o      (tgt_fetch),
      .brn_pred_ex_mem_bp_o    (pred_ex)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp)
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic t);
      brn_ex = 1'b1;
      taken  = t;
      pc_ex  = pc;
      tick();
      brn_ex = 1'b0;
      taken  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; pc_fetch = 32'h100; stall_iss = 0; flush_iss = 0; flush_ex = 0;
      brn_ex = 0; taken = 0; pc_ex = 0; tgt_ex = 0;
      tick(); tick();
      // 1: reset state
      chk("rst_pred_fetch", 32'(pred_fetch), 0);
      chk("rst_pred_ex", 32'(pred_ex), 0);
      chk("rst_ctr0", 32'(dut.u_ctr_tbl.mem[0]), 1);
      chk("rst_ctr63", 32'(dut.u_ctr_tbl.mem[63]), 1);
      chk("rst_tgt", tgt_fetch, 0);
      reset = 1'b0;

      // 2: saturating counter walk at idx 0
      upd(32'h100, 1); chk("t1_ctr", 32'(dut.u_ctr_tbl.mem[0]), 2);
      upd(32'h100, 1); chk("t2_ctr", 32'(dut.u_ctr_tbl.mem[0]), 3);
      chk("t2_pred", 32'(pred_fetch), 1);
      upd(32'h100, 1); chk("t3_sat_hi", 32'(dut.u_ctr_tbl.mem[0]), 3);
      upd(32'h100, 0); chk("nt1_ctr", 32'(dut.u_ctr_tbl.mem[0]), 2);
      upd(32'h100, 0); chk("nt2_ctr", 32'(dut.u_ctr_tbl.mem[0]), 1);
      chk("nt2_pred", 32'(pred_fetch), 0);
      upd(32'h100, 0); chk("nt3_ctr", 32'(dut.u_ctr_tbl.mem[0]), 0);
      upd(32'h100, 0); chk("nt4_sat_lo", 32'(dut.u_ctr_tbl.mem[0]), 0);

      // 3: pipeline latency, no stall then with a 2-cycle stall
      pc_fetch = 32'h104;
      upd(32'h100, 1); upd(32'h100, 1);
      tick();
      chk("lat_idle", 32'(pred_ex), 0);
      pc_fetch = 32'h100;
      tick(); pc_fetch = 32'h104;
      chk("lat_e1", 32'(pred_ex), 0);
      tick(); chk("lat_e2", 32'(pred_ex), 1);
      tick(); chk("lat_e3", 32'(pred_ex), 0);
      pc_fetch = 32'h100; stall_iss = 1;
      tick(); chk("stl_e1", 32'(pred_ex), 0);
      tick(); stall_iss = 0;
      chk("stl_e2", 32'(pred_ex), 0);
      tick(); pc_fetch = 32'h104;
      chk("stl_e3", 32'(pred_ex), 0);
      tick(); chk("stl_e4", 32'(pred_ex), 1);

      // 4: read/write collision at idx 2, then aliasing on idx 0
      pc_fetch = 32'h108; brn_ex = 1; taken = 1; pc_ex = 32'h108;
      #1 chk("coll_same_cyc", 32'(pred_fetch), 0);
      tick(); brn_ex = 0; taken = 0;
      chk("coll_next_cyc", 32'(pred_fetch), 1);
      pc_fetch = 32'h200;
      #1 chk("alias_0x200", 32'(pred_fetch), 1);
      upd(32'h200, 0); upd(32'h200, 0);
      pc_fetch = 32'h100;
      #1 chk("alias_0x100", 32'(pred_fetch), 0);

      // 5: flush priority, flush_ex with committing update, dual flush
      pc_fetch = 32'h108;
      tick();
      flush_iss = 1; stall_iss = 1; pc_fetch = 32'h104;
      tick(); flush_iss = 0; stall_iss = 0;
      chk("fl_iss_reg", 32'(dut.iss_pred), 0);
      chk("fl_iss_ex_old", 32'(pred_ex), 1);
      tick(); chk("fl_iss_ex_new", 32'(pred_ex), 0);
      pc_fetch = 32'h108;
      tick();
      pc_fetch = 32'h104; flush_ex = 1; brn_ex = 1; taken = 0; pc_ex = 32'h108;
      tick(); flush_ex = 0; brn_ex = 0;
      chk("fl_ex_pred", 32'(pred_ex), 0);
      chk("fl_ex_upd", 32'(dut.u_ctr_tbl.mem[2]), 1);
      upd(32'h10C, 1);
      pc_fetch = 32'h10C;
      tick(); tick();
      chk("both_pre_ex", 32'(pred_ex), 1);
      flush_iss = 1; flush_ex = 1;
      tick(); flush_iss = 0; flush_ex = 0; pc_fetch = 32'h104;
      chk("both_ex", 32'(pred_ex), 0);
      chk("both_iss", 32'(dut.iss_pred), 0);

      // reset mid-operation drops a pending update
      pc_fetch = 32'h10C;
      tick(); tick();
      brn_ex = 1; taken = 1; pc_ex = 32'h10C;
      reset = 1;
      #1 chk("mid_rst_ctr", 32'(dut.u_ctr_tbl.mem[3]), 1);
      chk("mid_rst_ex", 32'(pred_ex), 0);
      tick(); brn_ex = 0; taken = 0; reset = 0;
      chk("mid_rst_lost", 32'(dut.u_ctr_tbl.mem[3]), 1);

`ifdef BRANCH_PRED_BTB_EN
      // 6: BTB hit/miss and reset invalidation
      tgt_ex = 32'h180;
      upd(32'h100, 1);
      pc_fetch = 32'h100;
      #1 chk("btb_hit_pred", 32'(pred_fetch), 1);
      chk("btb_hit_tgt", tgt_fetch, 32'h180);
      pc_fetch = 32'h200;
      #1 chk("btb_miss_pred", 32'(pred_fetch), 0);
      chk("btb_miss_tgt", tgt_fetch, 0);
      reset = 1;
      tick(); reset = 0;
      pc_fetch = 32'h100;
      #1 chk("btb_rst_pred", 32'(pred_fetch), 0);
      chk("btb_rst_tgt", tgt_fetch, 0);
`else
      tgt_ex = 32'h180;
      upd(32'h100, 1);
      pc_fetch = 32'h100;
      #1 chk("nobtb_tgt", tgt_fetch, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
